// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : NUM_REGS x DATA_W register file, one synchronous write port,
//                two combinational read ports built from 2:1 mux trees.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam int c_num_regs = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_regs  [c_num_regs];
    // Heap-ordered trees: node n has children 2n+1 / 2n+2, leaves start at
    // c_num_regs-1, so leaf c_num_regs-1+r holds register r.
    logic [DATA_W-1:0] w_tree1 [2*c_num_regs-1];
    logic [DATA_W-1:0] w_tree2 [2*c_num_regs-1];

    generate
        for (genvar r = 0; r < c_num_regs; r++) begin : g_reg
            if ((ZERO_REG != 0) && (r == c_num_regs - 1)) begin : g_zero
                assign w_regs[r] = '0;
            end else begin : g_flop
                logic              w_sel;
                logic [DATA_W-1:0] r_q;

                assign w_sel = wr_en && (wr_addr == ADDR_W'(r));

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_sel) begin
                        r_q <= wr_data;
                    end
                end

                assign w_regs[r] = r_q;
            end

            assign w_tree1[c_num_regs-1+r] = w_regs[r];
            assign w_tree2[c_num_regs-1+r] = w_regs[r];
        end

        // The root steers on the address MSB, each level below on the next bit.
        for (genvar n = 0; n < c_num_regs - 1; n++) begin : g_node
            localparam int c_depth = $clog2(n + 2) - 1;

            assign w_tree1[n] = rd_addr1[ADDR_W-1-c_depth] ? w_tree1[2*n+2] : w_tree1[2*n+1];
            assign w_tree2[n] = rd_addr2[ADDR_W-1-c_depth] ? w_tree2[2*n+2] : w_tree2[2*n+1];
        end
    endgenerate

    assign rd_data1 = w_tree1[0];
    assign rd_data2 = w_tree2[0];

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Self-checking bench for reg_file with a queue scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file;

    localparam int c_data_w = 64;
    localparam int c_addr_w = 5;
    localparam int c_n      = 32;

    typedef struct {
        logic [c_addr_w-1:0] addr;
        logic [c_data_w-1:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_en;
    logic [c_addr_w-1:0] wr_addr;
    logic [c_data_w-1:0] wr_data;
    logic [c_addr_w-1:0] rd_addr1;
    logic [c_addr_w-1:0] rd_addr2;
    logic [c_data_w-1:0] rd_data1;
    logic [c_data_w-1:0] rd_data2;

    logic [c_data_w-1:0] model [c_n];
    exp_t                sb [$];
    exp_t                e;
    int                  n_checks = 0;
    int                  n_fail   = 0;

    reg_file #(.DATA_W(c_data_w), .ADDR_W(c_addr_w), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    always #5 clk = ~clk;

    // One clock edge with the given write-port / reset inputs; updates the model.
    task automatic drive_edge(input logic rst_v, input logic en,
                              input logic [c_addr_w-1:0] a, input logic [c_data_w-1:0] d);
        rst_n   = rst_v;
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            for (int i = 0; i < c_n; i++) model[i] = '0;
        end else if (en && (a != 5'd31)) begin
            model[a] = d;
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        drive_edge(1'b1, 1'b1, 5'd3, 64'h0000_0000_CAFE_0003);
        drive_edge(1'b1, 1'b1, 5'd17, 64'h0000_0000_CAFE_0017);
        rd_addr1 = 5'd3;
        #1;
        n_checks++;
        if (rd_data1 !== 64'h0000_0000_CAFE_0003) begin
            n_fail++;
            $display("FAIL reset_preload got=%h exp=%h", rd_data1, 64'h0000_0000_CAFE_0003);
        end
        drive_edge(1'b0, 1'b1, 5'd3, 64'hFFFF);
        for (int i = 0; i < c_n; i++) sb.push_back('{addr: 5'(i), data: 64'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr1 = e.addr;
            rd_addr2 = e.addr;
            #1;
            n_checks++;
            if (rd_data1 !== e.data || rd_data2 !== e.data) begin
                n_fail++;
                $display("FAIL reset_clear addr=%0d got1=%h got2=%h exp=%h",
                         e.addr, rd_data1, rd_data2, e.data);
            end
        end
    endtask

    task automatic test_reset_resume;
        drive_edge(1'b1, 1'b1, 5'd4, 64'h4444);
        drive_edge(1'b0, 1'b1, 5'd4, 64'h5555);
        drive_edge(1'b1, 1'b1, 5'd6, 64'h6666);
        sb.push_back('{addr: 5'd4, data: 64'h0});
        sb.push_back('{addr: 5'd6, data: 64'h6666});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr1 = e.addr;
            #1;
            n_checks++;
            if (rd_data1 !== e.data) begin
                n_fail++;
                $display("FAIL reset_resume addr=%0d got=%h exp=%h", e.addr, rd_data1, e.data);
            end
        end
    endtask

    task automatic test_write_sweep;
        for (int i = 0; i < 31; i++) begin
            drive_edge(1'b1, 1'b1, 5'(i), 64'h0101_0101_0000_0000 + 64'(i));
            sb.push_back('{addr: 5'(i), data: 64'h0101_0101_0000_0000 + 64'(i)});
            e = sb.pop_front();
            rd_addr1 = e.addr;
            rd_addr2 = e.addr;
            #1;
            n_checks++;
            if (rd_data1 !== e.data || rd_data2 !== e.data) begin
                n_fail++;
                $display("FAIL sweep addr=%0d got1=%h got2=%h exp=%h",
                         e.addr, rd_data1, rd_data2, e.data);
            end
        end
        for (int i = 0; i < c_n; i++) sb.push_back('{addr: 5'(i), data: model[i]});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr2 = e.addr;
            #1;
            n_checks++;
            if (rd_data2 !== e.data) begin
                n_fail++;
                $display("FAIL sweep_hold addr=%0d got=%h exp=%h", e.addr, rd_data2, e.data);
            end
        end
    endtask

    task automatic test_zero_reg;
        drive_edge(1'b1, 1'b1, 5'd31, 64'hDEAD_BEEF_DEAD_BEEF);
        sb.push_back('{addr: 5'd31, data: 64'h0});
        sb.push_back('{addr: 5'd30, data: 64'h0101_0101_0000_001E});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr1 = e.addr;
            rd_addr2 = e.addr;
            #1;
            n_checks++;
            if (rd_data1 !== e.data || rd_data2 !== e.data) begin
                n_fail++;
                $display("FAIL zero_reg addr=%0d got1=%h got2=%h exp=%h",
                         e.addr, rd_data1, rd_data2, e.data);
            end
        end
    endtask

    task automatic test_enable_gating;
        drive_edge(1'b1, 1'b0, 5'd5, 64'h1234);
        sb.push_back('{addr: 5'd5, data: 64'h0101_0101_0000_0005});
        e = sb.pop_front();
        rd_addr1 = e.addr;
        #1;
        n_checks++;
        if (rd_data1 !== e.data) begin
            n_fail++;
            $display("FAIL enable_gating got=%h exp=%h", rd_data1, e.data);
        end
    endtask

    task automatic test_read_during_write;
        rd_addr1 = 5'd7;
        rst_n    = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 64'hA5A5;
        sb.push_back('{addr: 5'd7, data: 64'h0101_0101_0000_0007});
        sb.push_back('{addr: 5'd7, data: 64'hA5A5});
        #1;
        e = sb.pop_front();
        n_checks++;
        if (rd_data1 !== e.data) begin
            n_fail++;
            $display("FAIL rdw_before got=%h exp=%h", rd_data1, e.data);
        end
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        model[7] = 64'hA5A5;
        e = sb.pop_front();
        n_checks++;
        if (rd_data1 !== e.data) begin
            n_fail++;
            $display("FAIL rdw_after got=%h exp=%h", rd_data1, e.data);
        end
    endtask

    task automatic test_dual_port;
        rd_addr1 = 5'd2;
        rd_addr2 = 5'd9;
        #1;
        n_checks++;
        if (rd_data1 !== model[2] || rd_data2 !== model[9]) begin
            n_fail++;
            $display("FAIL dual_port got1=%h exp1=%h got2=%h exp2=%h",
                     rd_data1, model[2], rd_data2, model[9]);
        end
        for (int i = 0; i < c_n; i++) begin
            rd_addr1 = 5'(i);
            #1;
            n_checks++;
            if (rd_data1 !== model[i] || rd_data2 !== model[9]) begin
                n_fail++;
                $display("FAIL dual_toggle1 addr=%0d got1=%h exp1=%h got2=%h exp2=%h",
                         i, rd_data1, model[i], rd_data2, model[9]);
            end
        end
        rd_addr1 = 5'd2;
        for (int i = 0; i < c_n; i++) begin
            rd_addr2 = 5'(i);
            #1;
            n_checks++;
            if (rd_data2 !== model[i] || rd_data1 !== model[2]) begin
                n_fail++;
                $display("FAIL dual_toggle2 addr=%0d got2=%h exp2=%h got1=%h exp1=%h",
                         i, rd_data2, model[i], rd_data1, model[2]);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        for (int i = 0; i < c_n; i++) model[i] = '0;
        drive_edge(1'b0, 1'b0, 5'd0, 64'h0);

        test_reset();
        test_reset_resume();
        test_write_sweep();
        test_zero_reg();
        test_enable_gating();
        test_read_during_write();
        test_dual_port();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
